// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline constants for the stall/flush controller.
// Holds the datapath word width and the default reset PC and NOP encodings.
package pipeline_stall_ctrl_pkg;

    localparam int unsigned WordWidth = 32;

    localparam logic [WordWidth-1:0] ResetPcDefault  = 32'h0000_0000;
    localparam logic [WordWidth-1:0] NopInstrDefault = 32'h0000_0000;

    // Width of the consecutive-stall watchdog counter.
    localparam int unsigned StallCntWidth = 4;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between fetch/hazard logic and the stall/flush controller.
// Members:
//   Stall, Flush              : hazard unit requests
//   IF_NextPC, IF_Instruction : fetch-side next PC and instruction read data
//   PC                        : registered program counter
//   ID_Instruction, ID_PC_Plus4, ID_Valid : IF/ID register contents
//   EX_Bubble                 : combinational bubble command for ID/EX
//   StallErr                  : sticky stall watchdog flag
//   StallCount, FlushCount    : perf counters, only with STALL_PERF_EN defined
// Modports: master drives the requests, slave is the controller.
interface pipeline_stall_ctrl_if;
    import pipeline_stall_ctrl_pkg::*;

    logic                 Stall;
    logic                 Flush;
    logic [WordWidth-1:0] IF_NextPC;
    logic [WordWidth-1:0] IF_Instruction;
    logic [WordWidth-1:0] PC;
    logic [WordWidth-1:0] ID_Instruction;
    logic [WordWidth-1:0] ID_PC_Plus4;
    logic                 ID_Valid;
    logic                 EX_Bubble;
    logic                 StallErr;
`ifdef STALL_PERF_EN
    logic [31:0]          StallCount;
    logic [31:0]          FlushCount;
`endif

    modport master (
        output Stall, Flush, IF_NextPC, IF_Instruction,
        input  PC, ID_Instruction, ID_PC_Plus4, ID_Valid, EX_Bubble, StallErr
`ifdef STALL_PERF_EN
        , input StallCount, FlushCount
`endif
    );

    modport slave (
        input  Stall, Flush, IF_NextPC, IF_Instruction,
        output PC, ID_Instruction, ID_PC_Plus4, ID_Valid, EX_Bubble, StallErr
`ifdef STALL_PERF_EN
        , output StallCount, FlushCount
`endif
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold (stall) and squash (flush).
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   hold_i        : keep all fields (takes priority over squash_i)
//   squash_i      : load NOP, zero PC+4, clear valid
//   instr_i       : fetched instruction
//   pc_plus4_i    : PC+4 of the fetched instruction
//   instr_o, pc_plus4_o, valid_o : registered IF/ID contents
module if_id_reg
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter logic [WordWidth-1:0] NOP_INSTR = NopInstrDefault
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold_i,
    input  logic                 squash_i,
    input  logic [WordWidth-1:0] instr_i,
    input  logic [WordWidth-1:0] pc_plus4_i,
    output logic [WordWidth-1:0] instr_o,
    output logic [WordWidth-1:0] pc_plus4_o,
    output logic                 valid_o
);

    logic [WordWidth-1:0] instr_q, instr_d;
    logic [WordWidth-1:0] pc_plus4_q, pc_plus4_d;
    logic                 valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (!hold_i) begin
            if (squash_i) begin
                instr_d    = NOP_INSTR;
                pc_plus4_d = '0;
                valid_d    = 1'b0;
            end else begin
                instr_d    = instr_i;
                pc_plus4_d = pc_plus4_i;
                valid_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: owns the PC register, the IF/ID register,
// the ID/EX bubble command and a consecutive-stall watchdog.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : pipeline_stall_ctrl_if.slave (see interface for members)
// Optional macro STALL_PERF_EN adds StallCount/FlushCount perf counters.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter logic [WordWidth-1:0] RESET_PC  = ResetPcDefault,
    parameter logic [WordWidth-1:0] NOP_INSTR = NopInstrDefault,
    parameter int unsigned          MAX_STALL = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_stall_ctrl_if.slave  bus
);

    localparam logic [StallCntWidth-1:0] MaxStallCnt = StallCntWidth'(MAX_STALL);

    logic [WordWidth-1:0]     pc_q, pc_d;
    logic [StallCntWidth-1:0] stall_cnt_q, stall_cnt_d;
    logic                     stall_err_q, stall_err_d;

    always_comb begin
        pc_d        = bus.Stall ? pc_q : bus.IF_NextPC;
        stall_cnt_d = '0;
        if (bus.Stall) begin
            stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + 1'b1;
        end
        // Sticky: sets on the edge the count reaches the limit.
        stall_err_d = stall_err_q | (bus.Stall && (stall_cnt_d >= MaxStallCnt));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold_i     (bus.Stall),
        .squash_i   (bus.Flush),
        .instr_i    (bus.IF_Instruction),
        .pc_plus4_i (pc_q + 32'd4),
        .instr_o    (bus.ID_Instruction),
        .pc_plus4_o (bus.ID_PC_Plus4),
        .valid_o    (bus.ID_Valid)
    );

    assign bus.PC        = pc_q;
    assign bus.EX_Bubble = bus.Stall;
    assign bus.StallErr  = stall_err_q;

`ifdef STALL_PERF_EN
    logic [31:0] stall_count_q, flush_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (bus.Stall) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
            // Flush under stall is ignored, so it is not counted either.
            if (bus.Flush && !bus.Stall) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign bus.StallCount = stall_count_q;
    assign bus.FlushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl (default parameters).
module tb_pipeline_stall_ctrl;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] next_pc;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] id_instr;
        logic [31:0] id_pc4;
        logic        id_valid;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] id_instr;
        logic [31:0] id_pc4;
        logic        id_valid;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    vec_t vecs[18];

    pipeline_stall_ctrl_if bus ();

    pipeline_stall_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic f, input logic [31:0] np,
                                input logic [31:0] ins, input logic [31:0] pc,
                                input logic [31:0] idi, input logic [31:0] id4,
                                input logic v, input logic e);
        vec_t r;
        r.stall = s; r.flush = f; r.next_pc = np; r.instr = ins;
        r.pc = pc; r.id_instr = idi; r.id_pc4 = id4; r.id_valid = v; r.err = e;
        return r;
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, " scoreboard"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, " PC"}, bus.PC, e.pc);
        chk({tag, " ID_Instruction"}, bus.ID_Instruction, e.id_instr);
        chk({tag, " ID_PC_Plus4"}, bus.ID_PC_Plus4, e.id_pc4);
        chk({tag, " ID_Valid"}, {31'd0, bus.ID_Valid}, {31'd0, e.id_valid});
        chk({tag, " StallErr"}, {31'd0, bus.StallErr}, {31'd0, e.err});
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] idi,
                            input logic [31:0] id4, input logic v, input logic e);
        exp_t x;
        x.pc = pc; x.id_instr = idi; x.id_pc4 = id4; x.id_valid = v; x.err = e;
        sb_q.push_back(x);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //            S  F  next_pc        instr          PC             ID_Instr       ID_PC4        V  Err
        vecs[0]  = mk(0, 0, 32'h4,         32'hA000_0000, 32'h4,         32'hA000_0000, 32'h4,        1, 0);
        vecs[1]  = mk(0, 0, 32'h8,         32'hA000_0004, 32'h8,         32'hA000_0004, 32'h8,        1, 0);
        vecs[2]  = mk(1, 0, 32'hC,         32'hA000_0008, 32'h8,         32'hA000_0004, 32'h8,        1, 0);
        vecs[3]  = mk(0, 0, 32'hC,         32'hA000_0008, 32'hC,         32'hA000_0008, 32'hC,        1, 0);
        vecs[4]  = mk(0, 0, 32'h10,        32'hA000_000C, 32'h10,        32'hA000_000C, 32'h10,       1, 0);
        vecs[5]  = mk(0, 1, 32'h40,        32'h8C01_0004, 32'h40,        32'h0,         32'h0,        0, 0);
        vecs[6]  = mk(0, 0, 32'h44,        32'hA000_0040, 32'h44,        32'hA000_0040, 32'h44,       1, 0);
        vecs[7]  = mk(1, 1, 32'h80,        32'hA000_0044, 32'h44,        32'hA000_0040, 32'h44,       1, 0);
        vecs[8]  = mk(0, 1, 32'h80,        32'hA000_0044, 32'h80,        32'h0,         32'h0,        0, 0);
        vecs[9]  = mk(1, 0, 32'h84,        32'hA000_0080, 32'h80,        32'h0,         32'h0,        0, 0);
        vecs[10] = mk(1, 0, 32'h84,        32'hA000_0080, 32'h80,        32'h0,         32'h0,        0, 0);
        vecs[11] = mk(0, 0, 32'h84,        32'hA000_0080, 32'h84,        32'hA000_0080, 32'h84,       1, 0);
        vecs[12] = mk(1, 0, 32'h88,        32'hA000_0084, 32'h84,        32'hA000_0080, 32'h84,       1, 0);
        vecs[13] = mk(1, 0, 32'h88,        32'hA000_0084, 32'h84,        32'hA000_0080, 32'h84,       1, 0);
        vecs[14] = mk(1, 0, 32'h88,        32'hA000_0084, 32'h84,        32'hA000_0080, 32'h84,       1, 1);
        vecs[15] = mk(0, 0, 32'h88,        32'hA000_0084, 32'h88,        32'hA000_0084, 32'h88,       1, 1);
        vecs[16] = mk(0, 0, 32'hFFFF_FFFC, 32'hA000_0088, 32'hFFFF_FFFC, 32'hA000_0088, 32'h8C,       1, 1);
        vecs[17] = mk(0, 0, 32'h0,         32'h0000_000B, 32'h0,         32'h0000_000B, 32'h0,        1, 1);

        rst_n              = 1'b0;
        bus.Stall          = 1'b0;
        bus.Flush          = 1'b0;
        bus.IF_NextPC      = '0;
        bus.IF_Instruction = '0;
        repeat (2) @(negedge clk);
        push_exp(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        pop_check("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            bus.Stall          = vecs[i].stall;
            bus.Flush          = vecs[i].flush;
            bus.IF_NextPC      = vecs[i].next_pc;
            bus.IF_Instruction = vecs[i].instr;
            #1;
            chk($sformatf("vec%0d EX_Bubble", i), {31'd0, bus.EX_Bubble}, {31'd0, vecs[i].stall});
            push_exp(vecs[i].pc, vecs[i].id_instr, vecs[i].id_pc4, vecs[i].id_valid, vecs[i].err);
            @(posedge clk);
            #1;
            pop_check($sformatf("vec%0d", i));
            @(negedge clk);
        end
`ifdef STALL_PERF_EN
        chk("StallCount table", bus.StallCount, 32'd7);
        chk("FlushCount table", bus.FlushCount, 32'd2);
`endif

        // Stall glitch between edges must not freeze the PC.
        bus.Stall          = 1'b0;
        bus.Flush          = 1'b0;
        bus.IF_NextPC      = 32'h4;
        bus.IF_Instruction = 32'hA000_0000;
        #2 bus.Stall = 1'b1;
        #1 bus.Stall = 1'b0;
        push_exp(32'h4, 32'hA000_0000, 32'h4, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        pop_check("glitch");
`ifdef STALL_PERF_EN
        chk("StallCount glitch", bus.StallCount, 32'd7);
`endif

        // Async reset in the middle of a two-cycle stall.
        @(negedge clk);
        bus.Stall     = 1'b1;
        bus.IF_NextPC = 32'h8;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        push_exp(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        pop_check("async reset");
        chk("EX_Bubble in reset", {31'd0, bus.EX_Bubble}, 32'd1);
`ifdef STALL_PERF_EN
        chk("StallCount reset", bus.StallCount, 32'd0);
        chk("FlushCount reset", bus.FlushCount, 32'd0);
`endif
        @(negedge clk);
        rst_n              = 1'b1;
        bus.Stall          = 1'b0;
        bus.IF_NextPC      = 32'h4;
        bus.IF_Instruction = 32'hA000_0000;
        push_exp(32'h4, 32'hA000_0000, 32'h4, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        pop_check("first fetch");

        // One stall after reset: a kept count (2) would reach the limit here.
        @(negedge clk);
        bus.Stall = 1'b1;
        push_exp(32'h4, 32'hA000_0000, 32'h4, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        pop_check("count cleared");
        @(negedge clk);
        bus.Stall = 1'b0;

        chk("scoreboard drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
